bus_poll_reader: RTL and testbench
==================================

BUS_POLL_READER -- requirements
Module: bus_poll_reader

Interface
REQ-001 Parameter: DEPTH, 4, capture buffer depth in entries; only 4 is supported.
REQ-002 CP  in  1  common clock; all state changes on the LOW-to-HIGH transition.
REQ-003 MR  in  1  master reset; one clock; reset is synchronous and active-low.
REQ-004 START  in  1  begin one poll sweep; sampled on the CP rising edge.
REQ-005 MASK  in  4  sources to poll; bit i set = poll source i; latched on an accepted START.
REQ-006 BUS  in  4  resolved shared three-state data bus driven by source registers' Y outputs.
REQ-007 OE  out  4  per-source output control, active-low; registered; at most one bit LOW at any time.
REQ-008 BUSY  out  1  HIGH while a sweep is in progress (any state other than IDLE).
REQ-009 DOUT  out  4  head-of-buffer data.
REQ-010 SRC  out  2  head-of-buffer source index.
REQ-011 VALID  out  1  HIGH when the buffer is non-empty.
REQ-012 READY  in  1  consumer accepts the head entry when VALID and READY are both HIGH at a rising edge.
REQ-013 COUNT  out  3  buffer occupancy, 0..4.

Function
REQ-014 FSM states: IDLE, SELECT, CAPTURE, GAP.
REQ-015 IDLE: OE=1111; START=1 with MASK!=0 latches MASK, picks lowest set bit i, goes to SELECT.
REQ-016 IDLE: START=1 with MASK=0 is ignored; START while BUSY=1 is ignored and the latched mask is unchanged.
REQ-017 SELECT, one cycle: OE[i]=0 (bus settle); always goes to CAPTURE.
REQ-018 CAPTURE: OE[i]=0; at the closing edge, if the buffer is not full or a pop occurs on the same edge, push {i, BUS}.
REQ-019 CAPTURE after a push: go to GAP if a higher set mask bit exists, else go to IDLE.
REQ-020 CAPTURE when the buffer is full with no pop: stay in CAPTURE with OE[i] held LOW; no push; no data loss.
REQ-021 GAP, one cycle: OE=1111 (bus turnaround, no overlapping enables); then select the next higher set mask bit and go to SELECT.
REQ-022 Per-source latency: START edge -> OE[i] LOW for 2 cycles -> BUS sampled at the 2nd edge; a sweep of n sources takes 3n-1 cycles after START when there is no stall.
REQ-023 Buffer is first-word-fall-through: DOUT/SRC/VALID reflect the head combinationally from registers; a pop advances the head on the edge.
REQ-024 Push and pop on the same edge: COUNT unchanged; push with full buffer is allowed only with a simultaneous pop.
REQ-025 Pop when empty is ignored; pointers wrap modulo 4; COUNT=4 means full, COUNT=0 means empty.
REQ-026 DOUT/SRC are don't-care when VALID=0.

Reset
REQ-027 MR=0 at an edge: state IDLE, OE=1111, BUSY=0, COUNT=0, VALID=0, pointers=0, latched mask=0.
REQ-028 Reset mid-sweep releases OE on the same edge, discards buffered data, and abandons the sweep; MR overrides START, READY, and push/pop.

Verification
REQ-029 Reset, then START=1, MASK=1010, BUS driven 5 while OE[1]=0 and 9 while OE[3]=0, READY=1 -> OE sequence 1101,1101,1111,0111,0111,1111; entries {1,5} then {3,9}; BUSY HIGH for 5 cycles.
REQ-030 READY=0, MASK=1111, two sweeps -> 4 entries then stall in CAPTURE with OE=1110 held; COUNT=4; raising READY for one cycle pushes {0,data} with COUNT staying at 4.
REQ-031 START with MASK=0000 -> BUSY stays 0 and OE stays 1111; START during a sweep -> sweep unchanged.
REQ-032 MR=0 asserted during CAPTURE with COUNT=2 -> next cycle OE=1111, COUNT=0, VALID=0, BUSY=0.
REQ-033 Every cycle of a random START/MASK/READY run -> at most one OE bit LOW; at least one all-HIGH cycle between different low bits; buffer order and COUNT match a reference queue model.

Source files
------------

// File: rtl/bus_poll_reader.sv
// Polls a masked set of three-state bus sources one at a time and queues
// {source, data} captures into a small first-word-fall-through buffer.
module bus_poll_reader #(
  parameter int DEPTH = 4
) (
  input  logic       CP,
  input  logic       MR,
  input  logic       START,
  input  logic [3:0] MASK,
  input  logic [3:0] BUS,
  input  logic       READY,
  output logic [3:0] OE,
  output logic       BUSY,
  output logic [3:0] DOUT,
  output logic [1:0] SRC,
  output logic       VALID,
  output logic [2:0] COUNT
);

  typedef enum logic [1:0] {IDLE, SELECT, CAPTURE, GAP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  oe_q, oe_d;
  logic [5:0]  mem [DEPTH];
  logic [1:0]  wptr_q, rptr_q;
  logic [2:0]  count_q;
  logic        full, push, pop;

  function automatic logic [1:0] first_set(input logic [3:0] m);
    first_set = 2'd0;
    for (int j = 3; j >= 0; j--)
      if (m[j]) first_set = 2'(j);
  endfunction

  function automatic logic [3:0] above(input logic [3:0] m, input logic [1:0] i);
    above = m & (4'b1110 << i);
  endfunction

  assign full  = (count_q == 3'(DEPTH));
  assign VALID = (count_q != 3'd0);
  assign pop   = VALID && READY;
  // A full buffer can still take a capture when the head leaves on the same edge.
  assign push  = (state_q == CAPTURE) && (!full || pop);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (START && (MASK != 4'b0000)) begin
          mask_d  = MASK;
          idx_d   = first_set(MASK);
          state_d = SELECT;
        end
      end
      SELECT:  state_d = CAPTURE;
      CAPTURE: begin
        if (push) state_d = (above(mask_q, idx_q) != 4'b0000) ? GAP : IDLE;
      end
      GAP: begin
        idx_d   = first_set(above(mask_q, idx_q));
        state_d = SELECT;
      end
      default: state_d = IDLE;
    endcase
    oe_d = 4'b1111;
    if ((state_d == SELECT) || (state_d == CAPTURE)) oe_d[idx_d] = 1'b0;
  end

  always_ff @(posedge CP) begin
    if (!MR) begin
      state_q <= IDLE;
      mask_q  <= 4'b0000;
      idx_q   <= 2'd0;
      oe_q    <= 4'b1111;
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      oe_q    <= oe_d;
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop)  rptr_q <= rptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (MR && push) mem[wptr_q] <= {idx_q, BUS};
  end

  assign OE    = oe_q;
  assign BUSY  = (state_q != IDLE);
  assign COUNT = count_q;
  assign DOUT  = mem[rptr_q][3:0];
  assign SRC   = mem[rptr_q][5:4];

endmodule

// File: tb/tb_bus_poll_reader.sv
// Bench for bus_poll_reader: directed scenarios plus a randomized run checked
// against a transaction-level queue model of the sweep and buffer.
module tb_bus_poll_reader;

  logic       CP = 1'b0;
  logic       MR = 1'b1;
  logic       START = 1'b0;
  logic       READY = 1'b0;
  logic [3:0] MASK = 4'b0000;
  logic [3:0] BUS;
  logic [3:0] OE, DOUT;
  logic       BUSY, VALID;
  logic [1:0] SRC;
  logic [2:0] COUNT;
  logic [3:0] src_data [4];

  int checks = 0;
  int errors = 0;

  // Model: sources still to poll, edges spent on the current source, gap flag.
  int         pend [$];
  logic [5:0] q [$];
  int         k;
  bit         in_gap;

  always #5 CP = ~CP;

  always_comb begin
    BUS = 4'h0;
    for (int i = 0; i < 4; i++)
      if (!OE[i]) BUS = src_data[i];
  end

  bus_poll_reader #(.DEPTH(4)) dut (
    .CP(CP), .MR(MR), .START(START), .MASK(MASK), .BUS(BUS), .READY(READY),
    .OE(OE), .BUSY(BUSY), .DOUT(DOUT), .SRC(SRC), .VALID(VALID), .COUNT(COUNT)
  );

  function void model_edge();
    bit         pop, push;
    logic [5:0] pv;
    push = 0;
    pv   = 6'h0;
    if (!MR) begin
      q.delete(); pend.delete(); in_gap = 0; k = 0;
      return;
    end
    pop = (q.size() > 0) && READY;
    if (in_gap) begin
      in_gap = 0; k = 0;
    end else if (pend.size() == 0) begin
      if (START && MASK != 4'b0000) begin
        for (int i = 0; i < 4; i++) if (MASK[i]) pend.push_back(i);
        k = 0;
      end
    end else if (k == 0) begin
      k = 1;
    end else if (q.size() < 4 || pop) begin
      push = 1;
      pv = {2'(pend[0]), src_data[pend[0]]};
      void'(pend.pop_front());
      if (pend.size() > 0) in_gap = 1;
    end
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(pv);
  endfunction

  function logic [3:0] exp_oe();
    if (pend.size() > 0 && !in_gap) return ~(4'b0001 << pend[0]);
    return 4'b1111;
  endfunction

  task automatic step();
    @(posedge CP);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    MR = 1'b0; START = 1'b0; READY = 1'b0;
    step();
    MR = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) src_data[i] = 4'h0;
    START = 1'b1; MASK = 4'b1111;
    do_reset();
    MASK = 4'b0000;
    checks++; if (OE !== 4'b1111) begin errors++; $display("FAIL reset_oe got %b exp 1111", OE); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", COUNT); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", VALID); end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_seq [6];
    logic [5:0] got [$];
    int busy_n = 0;
    exp_seq = '{4'b1101, 4'b1101, 4'b1111, 4'b0111, 4'b0111, 4'b1111};
    do_reset();
    src_data[1] = 4'd5; src_data[3] = 4'd9;
    READY = 1'b1; START = 1'b1; MASK = 4'b1010;
    step();
    START = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (OE !== exp_seq[c]) begin errors++; $display("FAIL sweep_oe[%0d] got %b exp %b", c, OE, exp_seq[c]); end
      if (BUSY) busy_n++;
      if (VALID) got.push_back({SRC, DOUT});
      if (c < 5) step();
    end
    checks++; if (busy_n != 5) begin errors++; $display("FAIL sweep_busy_cycles got %0d exp 5", busy_n); end
    checks++;
    if (got.size() != 2 || got[0] !== {2'd1, 4'd5} || got[1] !== {2'd3, 4'd9}) begin
      errors++; $display("FAIL sweep_entries got n=%0d first=%h exp n=2 15,39", got.size(), got.size() > 0 ? got[0] : 6'h0);
    end
  endtask

  task automatic test_stall();
    logic [3:0] d [4];
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) begin d[i] = 4'($urandom); src_data[i] = d[i]; end
    READY = 1'b0; START = 1'b1; MASK = 4'b1111;
    step();
    START = 1'b0;
    n = 0;
    while (BUSY && n < 30) begin step(); n++; end
    checks++; if (BUSY) begin errors++; $display("FAIL stall_first_sweep_done got busy=1 exp 0"); end
    checks++; if (COUNT !== 3'd4) begin errors++; $display("FAIL stall_count_full got %0d exp 4", COUNT); end
    src_data[0] = ~d[0];
    START = 1'b1;
    step();
    START = 1'b0;
    for (int c = 0; c < 4; c++) step();
    checks++; if (OE !== 4'b1110) begin errors++; $display("FAIL stall_oe_held got %b exp 1110", OE); end
    checks++; if (COUNT !== 3'd4 || BUSY !== 1'b1) begin errors++; $display("FAIL stall_state got count=%0d busy=%b exp 4 1", COUNT, BUSY); end
    checks++; if ({SRC, DOUT} !== {2'd0, d[0]}) begin errors++; $display("FAIL stall_head got %h exp %h", {SRC, DOUT}, {2'd0, d[0]}); end
    READY = 1'b1;
    step();
    READY = 1'b0;
    checks++; if (COUNT !== 3'd4) begin errors++; $display("FAIL stall_pushpop_count got %0d exp 4", COUNT); end
    checks++; if (OE !== 4'b1111) begin errors++; $display("FAIL stall_release_oe got %b exp 1111", OE); end
    checks++; if ({SRC, DOUT} !== {2'd1, d[1]}) begin errors++; $display("FAIL stall_new_head got %h exp %h", {SRC, DOUT}, {2'd1, d[1]}); end
    READY = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      checks++;
      if (COUNT !== 3'(q.size()) || (q.size() > 0 && {SRC, DOUT} !== q[0])) begin
        errors++; $display("FAIL stall_drain[%0d] got count=%0d head=%h exp count=%0d head=%h", c, COUNT, {SRC, DOUT}, q.size(), q.size() > 0 ? q[0] : 6'h0);
      end
    end
  endtask

  task automatic test_ignored_start();
    do_reset();
    READY = 1'b1; START = 1'b1; MASK = 4'b0000;
    step();
    checks++; if (BUSY !== 1'b0 || OE !== 4'b1111) begin errors++; $display("FAIL zero_mask got busy=%b oe=%b exp 0 1111", BUSY, OE); end
    MASK = 4'b0001;
    step();
    MASK = 4'b1110;
    step();
    checks++; if (OE !== 4'b1110) begin errors++; $display("FAIL busy_start_oe got %b exp 1110", OE); end
    START = 1'b0;
    step();
    checks++; if (BUSY !== 1'b0 || OE !== 4'b1111) begin errors++; $display("FAIL busy_start_end got busy=%b oe=%b exp 0 1111", BUSY, OE); end
    step();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL busy_start_no_resweep got busy=%b exp 0", BUSY); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) src_data[i] = 4'($urandom);
    READY = 1'b0; START = 1'b1; MASK = 4'b1111;
    step();
    START = 1'b0;
    for (int c = 0; c < 7; c++) step();
    checks++; if (OE !== 4'b1011 || COUNT !== 3'd2) begin errors++; $display("FAIL mid_pre got oe=%b count=%0d exp 1011 2", OE, COUNT); end
    MR = 1'b0; READY = 1'b1; START = 1'b1;
    step();
    MR = 1'b1; START = 1'b0; READY = 1'b0;
    checks++;
    if (OE !== 4'b1111 || COUNT !== 3'd0 || VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL mid_reset got oe=%b count=%0d valid=%b busy=%b exp 1111 0 0 0", OE, COUNT, VALID, BUSY);
    end
  endtask

  task automatic test_random();
    logic [3:0] prev_oe = 4'b1111;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      START = ($urandom_range(0, 3) == 0);
      MASK  = 4'($urandom);
      READY = ($urandom_range(0, 2) == 0);
      MR    = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < 4; i++) src_data[i] = 4'($urandom);
      step();
      checks++;
      if (OE !== exp_oe() || BUSY !== (pend.size() > 0) || COUNT !== 3'(q.size()) || VALID !== (q.size() > 0)) begin
        errors++; $display("FAIL rand_ctrl[%0d] got oe=%b busy=%b count=%0d valid=%b exp %b %b %0d %b", c, OE, BUSY, COUNT, VALID, exp_oe(), pend.size() > 0, q.size(), q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if ({SRC, DOUT} !== q[0]) begin errors++; $display("FAIL rand_head[%0d] got %h exp %h", c, {SRC, DOUT}, q[0]); end
      end
      checks++;
      if ($countones(~OE) > 1) begin errors++; $display("FAIL rand_onehot[%0d] got oe=%b exp at most one low", c, OE); end
      if ($countones(~OE) == 1 && $countones(~prev_oe) == 1) begin
        checks++;
        if (OE !== prev_oe) begin errors++; $display("FAIL rand_gap[%0d] got %b after %b exp all-high between", c, OE, prev_oe); end
      end
      prev_oe = OE;
    end
    MR = 1'b1;
  endtask

  initial begin
    pend.delete(); q.delete(); k = 0; in_gap = 0;
    test_reset();
    test_sweep();
    test_stall();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
